// File: rtl/fifo_to_axi4_wr.sv
// Drains a first-word-fall-through write FIFO into memory as fixed-length AXI4 INCR write
// bursts. Each burst runs AW, then W, then B, with one burst outstanding at a time. The
// burst byte address walks a ring [WR_AXI_BYTE_ADDR_BEGIN, WR_AXI_BYTE_ADDR_END).
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   WR_AXI_BYTE_ADDR_END   exclusive end of the address ring (zero-extended)
//   addr_clr               pulse: restart the ring at WR_AXI_BYTE_ADDR_BEGIN
//   fifo_*                 FWFT FIFO read side (pop, head word, fill count, reset busy)
//   m_axi_aw*/w*/b*        AXI4 write address, write data and write response channels
module fifo_to_axi4_wr #(
   parameter int unsigned                  AXI_DATA_WIDTH         = 64,
   parameter int unsigned                  AXI_ADDR_WIDTH         = 32,
   parameter int unsigned                  AXI_ID_WIDTH           = 4,
   parameter logic [AXI_ADDR_WIDTH-1:0]    WR_AXI_BYTE_ADDR_BEGIN = '0,
   parameter logic [AXI_ID_WIDTH-1:0]      AXI_ID                 = '0,
   parameter logic [7:0]                   AXI_BURST_LEN          = 8'd31,
   parameter int unsigned                  FIFO_ADDR_WIDTH        = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [23:0]                   WR_AXI_BYTE_ADDR_END,
   input  logic                          addr_clr,
   output logic                          fifo_rdreq,
   input  logic [AXI_DATA_WIDTH-1:0]     fifo_rddata,
   input  logic [FIFO_ADDR_WIDTH-1:0]    fifo_rd_cnt,
   input  logic                          fifo_rst_busy,
   output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
   output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [7:0]                    m_axi_awlen,
   output logic [2:0]                    m_axi_awsize,
   output logic [1:0]                    m_axi_awburst,
   output logic                          m_axi_awlock,
   output logic [3:0]                    m_axi_awcache,
   output logic [2:0]                    m_axi_awprot,
   output logic [3:0]                    m_axi_awqos,
   output logic [3:0]                    m_axi_awregion,
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                          m_axi_wlast,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   input  logic [AXI_ID_WIDTH-1:0]       m_axi_bid,
   input  logic [1:0]                    m_axi_bresp,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready
);

   localparam int unsigned BEATS = int'(AXI_BURST_LEN) + 1;
   localparam int unsigned AW1   = AXI_ADDR_WIDTH + 1;
   // One extra bit so the ring-end compare cannot be fooled by address overflow.
   localparam logic [AXI_ADDR_WIDTH:0] ADDR_STEP = AW1'(BEATS * (AXI_DATA_WIDTH / 8));
   localparam logic [2:0] AW_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

   typedef enum logic [3:0] {
      StIdle   = 4'b0001,
      StWrAddr = 4'b0010,
      StWrData = 4'b0100,
      StWrResp = 4'b1000
   } state_e;

   state_e                       state_q, state_d;
   logic                         awvalid_q, awvalid_d;
   logic                         wvalid_q, wvalid_d;
   logic [AXI_ADDR_WIDTH-1:0]    awaddr_q, awaddr_d;
   logic [7:0]                   beat_cnt_q, beat_cnt_d;
   logic                         clr_pend_q, clr_pend_d;

   logic                         start_ok;
   logic                         w_hs;
   logic                         last_beat;
   logic                         resp_ok;
   logic [AXI_ADDR_WIDTH:0]      addr_nxt;
   logic [AXI_ADDR_WIDTH:0]      addr_end;

   assign start_ok  = !fifo_rst_busy && (32'(fifo_rd_cnt) >= BEATS);
   assign w_hs      = wvalid_q && m_axi_wready;
   assign last_beat = (beat_cnt_q == AXI_BURST_LEN);
   assign resp_ok   = (m_axi_bresp == 2'b00) && (m_axi_bid == AXI_ID);
   assign addr_nxt  = {1'b0, awaddr_q} + ADDR_STEP;
   assign addr_end  = AW1'(WR_AXI_BYTE_ADDR_END);

   always_comb begin
      state_d    = state_q;
      awvalid_d  = awvalid_q;
      wvalid_d   = wvalid_q;
      awaddr_d   = awaddr_q;
      beat_cnt_d = beat_cnt_q;
      clr_pend_d = clr_pend_q;
      unique case (state_q)
         StIdle: begin
            if (addr_clr) awaddr_d = WR_AXI_BYTE_ADDR_BEGIN;
            if (start_ok) begin
               state_d   = StWrAddr;
               awvalid_d = 1'b1;
            end
         end
         StWrAddr: begin
            if (addr_clr) clr_pend_d = 1'b1;
            if (m_axi_awready) begin
               awvalid_d = 1'b0;
               wvalid_d  = 1'b1;
               state_d   = StWrData;
            end
         end
         StWrData: begin
            if (addr_clr) clr_pend_d = 1'b1;
            if (w_hs) begin
               if (last_beat) begin
                  beat_cnt_d = '0;
                  wvalid_d   = 1'b0;
                  state_d    = StWrResp;
               end else begin
                  beat_cnt_d = beat_cnt_q + 8'd1;
               end
            end
         end
         StWrResp: begin
            if (addr_clr) clr_pend_d = 1'b1;
            if (m_axi_bvalid) begin
               state_d    = StIdle;
               clr_pend_d = 1'b0;
               // A pending clear wins over the response; failed bursts are not retried,
               // the same region is simply rewritten next time.
               if (clr_pend_q || addr_clr) begin
                  awaddr_d = WR_AXI_BYTE_ADDR_BEGIN;
               end else if (resp_ok) begin
                  awaddr_d = (addr_nxt >= addr_end) ? WR_AXI_BYTE_ADDR_BEGIN
                                                    : addr_nxt[AXI_ADDR_WIDTH-1:0];
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         awaddr_q   <= WR_AXI_BYTE_ADDR_BEGIN;
         beat_cnt_q <= '0;
         clr_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         awvalid_q  <= awvalid_d;
         wvalid_q   <= wvalid_d;
         awaddr_q   <= awaddr_d;
         beat_cnt_q <= beat_cnt_d;
         clr_pend_q <= clr_pend_d;
      end
   end

   assign fifo_rdreq     = w_hs;
   assign m_axi_awid     = AXI_ID;
   assign m_axi_awaddr   = awaddr_q;
   assign m_axi_awlen    = AXI_BURST_LEN;
   assign m_axi_awsize   = AW_SIZE;
   assign m_axi_awburst  = 2'b01;
   assign m_axi_awlock   = 1'b0;
   assign m_axi_awcache  = 4'b0000;
   assign m_axi_awprot   = 3'b000;
   assign m_axi_awqos    = 4'b0000;
   assign m_axi_awregion = 4'b0000;
   assign m_axi_awvalid  = awvalid_q;
   assign m_axi_wdata    = fifo_rddata;
   assign m_axi_wstrb    = '1;
   assign m_axi_wlast    = last_beat && wvalid_q;
   assign m_axi_wvalid   = wvalid_q;
   assign m_axi_bready   = (state_q == StWrResp);

endmodule
